func_unit: RTL and testbench

- Two-input universal logic function unit.
- The 4-bit selector `sel` is the truth table of the function applied to single-bit operands `a` and `b`.
- All 16 Boolean functions of two variables are selectable. `sel`=0 is constant 0; `sel`=15 is constant 1.
- Sits in the datapath as a configurable bit-level ALU cell. It provides:
  - a combinational result;
  - a registered copy of the result;
  - operand-dependency flags.

---
 rtl/func_unit.sv | 41 ++++
 tb/tb_func_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/func_unit.sv
// Two-input universal logic cell: sel is the truth table indexed by {a,b}.
// Optional dependency flags are built only when FUNC_DEP_FLAGS_EN is defined.
`timescale 1ns/1ps
module func_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       z,
  output logic       z_q,
  output logic       dep_a,
  output logic       dep_b
);

  logic [1:0] idx;

  assign idx = {a, b};
  assign z   = sel[idx];

  // Reset wins over capture; en=0 holds the last captured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
    end else if (en) begin
      z_q <= z;
    end
  end

`ifdef FUNC_DEP_FLAGS_EN
  // A matters if flipping it (index bit 1) changes the output for some b;
  // likewise for B with index bit 0.
  assign dep_a = (sel[0] ^ sel[2]) | (sel[1] ^ sel[3]);
  assign dep_b = (sel[0] ^ sel[1]) | (sel[2] ^ sel[3]);
`else
  assign dep_a = 1'b0;
  assign dep_b = 1'b0;
`endif

endmodule

// File: tb/tb_func_unit.sv
// Directed self-checking bench for func_unit: combinational function map,
// registered capture/hold/reset behaviour and dependency flags.
`timescale 1ns/1ps
module tb_func_unit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] sel;
  logic       a;
  logic       b;
  logic       z;
  logic       z_q;
  logic       dep_a;
  logic       dep_b;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  func_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .sel   (sel),
    .a     (a),
    .b     (b),
    .z     (z),
    .z_q   (z_q),
    .dep_a (dep_a),
    .dep_b (dep_b)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference function map written as Boolean expressions.
  function automatic logic model_f(input int s, input logic ma, input logic mb);
    case (s)
      0:  return 1'b0;
      1:  return ~(ma | mb);
      2:  return ~ma & mb;
      3:  return ~ma;
      4:  return ma & ~mb;
      5:  return ~mb;
      6:  return ma ^ mb;
      7:  return ~(ma & mb);
      8:  return ma & mb;
      9:  return ~(ma ^ mb);
      10: return mb;
      11: return ~ma | mb;
      12: return ma;
      13: return ma | ~mb;
      14: return ma | mb;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic model_dep_a(input int s);
`ifdef FUNC_DEP_FLAGS_EN
    return (model_f(s, 1'b0, 1'b0) != model_f(s, 1'b1, 1'b0)) ||
           (model_f(s, 1'b0, 1'b1) != model_f(s, 1'b1, 1'b1));
`else
    return (s < 0);
`endif
  endfunction

  function automatic logic model_dep_b(input int s);
`ifdef FUNC_DEP_FLAGS_EN
    return (model_f(s, 1'b0, 1'b0) != model_f(s, 1'b0, 1'b1)) ||
           (model_f(s, 1'b1, 1'b0) != model_f(s, 1'b1, 1'b1));
`else
    return (s < 0);
`endif
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [0:3] seq_exp [4];
  int         seq_sel [4];
  logic       dep_exp_a;
  logic       dep_exp_b;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    sel   = 4'd0;
    a     = 1'b0;
    b     = 1'b0;
    #2;
    check("reset_zq", z_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // sel=0 constant zero, swept repeatedly
    sel = 4'd0;
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 4; i++) begin
        {a, b} = i[1:0];
        #1;
        check($sformatf("zero_r%0d_ab%0d", r, i), z, 1'b0);
      end
    end

    // AND, OR, XOR, XNOR hand-written sequences in order ab=00,01,10,11
    seq_sel[0] = 8;  seq_exp[0] = 4'b0001;
    seq_sel[1] = 14; seq_exp[1] = 4'b0111;
    seq_sel[2] = 6;  seq_exp[2] = 4'b0110;
    seq_sel[3] = 9;  seq_exp[3] = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      sel = seq_sel[k][3:0];
      for (int i = 0; i < 4; i++) begin
        {a, b} = i[1:0];
        #1;
        check($sformatf("seq_sel%0d_ab%0d", seq_sel[k], i), z, seq_exp[k][i]);
      end
    end

    // full map and dependency flags for every sel
    for (int s = 0; s < 16; s++) begin
      sel = s[3:0];
      for (int i = 0; i < 4; i++) begin
        {a, b} = i[1:0];
        #1;
        check($sformatf("map_sel%0d_ab%0d", s, i), z, model_f(s, a, b));
        if (s == 15) check($sformatf("one_ab%0d", i), z, 1'b1);
      end
      check($sformatf("dep_a_sel%0d", s), dep_a, model_dep_a(s));
      check($sformatf("dep_b_sel%0d", s), dep_b, model_dep_b(s));
    end

    // directed dependency flags
`ifdef FUNC_DEP_FLAGS_EN
    sel = 4'd12; #1; check("dep12_a", dep_a, 1'b1); check("dep12_b", dep_b, 1'b0);
    sel = 4'd10; #1; check("dep10_a", dep_a, 1'b0); check("dep10_b", dep_b, 1'b1);
    sel = 4'd6;  #1; check("dep6_a",  dep_a, 1'b1); check("dep6_b",  dep_b, 1'b1);
    sel = 4'd0;  #1; check("dep0_a",  dep_a, 1'b0); check("dep0_b",  dep_b, 1'b0);
`else
    sel = 4'd12; #1; check("dep12_a", dep_a, 1'b0); check("dep12_b", dep_b, 1'b0);
    sel = 4'd10; #1; check("dep10_a", dep_a, 1'b0); check("dep10_b", dep_b, 1'b0);
    sel = 4'd6;  #1; check("dep6_a",  dep_a, 1'b0); check("dep6_b",  dep_b, 1'b0);
    sel = 4'd0;  #1; check("dep0_a",  dep_a, 1'b0); check("dep0_b",  dep_b, 1'b0);
`endif

    // registered path: capture then hold
    @(negedge clk);
    en = 1'b1; sel = 4'd8; a = 1'b1; b = 1'b1;
    tick();
    check("cap_and11", z_q, 1'b1);
    @(negedge clk);
    en = 1'b0; a = 1'b0;
    tick();
    check("hold_zq", z_q, 1'b1);
    check("hold_z", z, 1'b0);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("cap_zero", z_q, 1'b0);
    @(negedge clk);
    a = 1'b1;
    tick();
    check("recap_one", z_q, 1'b1);

    // asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_zq", z_q, 1'b0);
    check("rst_z_unaffected", z, 1'b1);
    tick();
    check("rst_hold_en1", z_q, 1'b0);
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_en0", z_q, 1'b0);
    @(negedge clk);
    en = 1'b1;
    tick();
    check("post_rst_cap", z_q, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
